// File: rtl/gate_identifier.sv
// gate_identifier: rebuilds a 2-input gate truth table from (a, b, s) samples and names the function.
// Optional build macro GATE_ID_TIMEOUT_EN adds an idle timeout while collecting.
module gate_identifier #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       a,
    input  logic       b,
    input  logic       s,
    output logic [3:0] tt,
    output logic [3:0] known,
    output logic       done,
    output logic       conflict,
    output logic       timeout,
    output logic [7:0] sample_cnt,
    output logic       is_and,
    output logic       is_nand,
    output logic       is_or,
    output logic       is_nor,
    output logic       is_xor,
    output logic       is_xnor
);

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] COLLECT  = 2'b01;
    localparam logic [1:0] DONE_ST  = 2'b10;
    localparam logic [1:0] ERROR_ST = 2'b11;

    logic [1:0] state;
    logic       accept;
    logic [1:0] idx;
    logic       row_hit;
    logic       row_bad;
    logic [3:0] known_nxt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        idx       = {a, b};
        accept    = in_valid && (state == COLLECT) && !start;
        row_hit   = known[idx];
        row_bad   = row_hit && (tt[idx] != s);
        known_nxt = known | (4'b0001 << idx);
    end

`ifdef GATE_ID_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout_r;
    logic              idle_expire;

    assign idle_expire = (state == COLLECT) && !start && !accept && (idle_cnt == IDLE_LAST);
    assign timeout     = timeout_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (start || accept || state != COLLECT) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_r <= 1'b0;
        end else if (start) begin
            timeout_r <= 1'b0;
        end else if (idle_expire) begin
            timeout_r <= 1'b1;
        end
    end
`else
    logic       idle_expire;
    logic [31:0] timeout_cfg_unused;

    assign timeout_cfg_unused = 32'(TIMEOUT_CYCLES);
    assign idle_expire        = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tt         <= 4'b0000;
            known      <= 4'b0000;
            sample_cnt <= 8'd0;
            conflict   <= 1'b0;
        end else if (start) begin
            state      <= COLLECT;
            tt         <= 4'b0000;
            known      <= 4'b0000;
            sample_cnt <= 8'd0;
            conflict   <= 1'b0;
        end else if (accept) begin
            sample_cnt <= sat_inc(sample_cnt);
            if (row_bad) begin
                // first observation of the row is kept; the contradiction only flags
                conflict <= 1'b1;
                state    <= ERROR_ST;
            end else begin
                if (!row_hit) tt[idx] <= s;
                known <= known_nxt;
                if (known_nxt == 4'b1111) state <= DONE_ST;
            end
        end else if (idle_expire) begin
            state <= ERROR_ST;
        end
    end

    assign in_ready = (state == COLLECT);
    assign done     = (state == DONE_ST);

    always_comb begin
        is_and  = done && (tt == 4'b1000);
        is_nand = done && (tt == 4'b0111);
        is_or   = done && (tt == 4'b1110);
        is_nor  = done && (tt == 4'b0001);
        is_xor  = done && (tt == 4'b0110);
        is_xnor = done && (tt == 4'b1001);
    end

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench for gate_identifier; expectations depend on GATE_ID_TIMEOUT_EN like the RTL.
module tb_gate_identifier;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       s = 1'b0;
    logic [3:0] tt;
    logic [3:0] known;
    logic       done;
    logic       conflict;
    logic       timeout;
    logic [7:0] sample_cnt;
    logic       is_and, is_nand, is_or, is_nor, is_xor, is_xnor;

    int total = 0;
    int bad   = 0;

    gate_identifier #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .s(s), .tt(tt), .known(known),
        .done(done), .conflict(conflict), .timeout(timeout), .sample_cnt(sample_cnt),
        .is_and(is_and), .is_nand(is_nand), .is_or(is_or), .is_nor(is_nor),
        .is_xor(is_xor), .is_xnor(is_xnor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic va, input logic vb, input logic vs);
        in_valid = 1'b1;
        a = va;
        b = vb;
        s = vs;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] flags();
        return {2'b00, is_and, is_nand, is_or, is_nor, is_xor, is_xnor};
    endfunction

    initial begin
        // reset
        tick();
        chk("rst_tt", {4'h0, tt}, 8'h00);
        chk("rst_ready", {7'd0, in_ready}, 8'h00);
        chk("rst_done", {7'd0, done}, 8'h00);
        reset_n = 1'b1;
        tick();

        // AND table
        do_start();
        chk("and_ready", {7'd0, in_ready}, 8'h01);
        send(0, 0, 0); send(0, 1, 0); send(1, 0, 0);
        chk("and_not_done", {7'd0, done}, 8'h00);
        send(1, 1, 1);
        chk("and_done", {7'd0, done}, 8'h01);
        chk("and_tt", {4'h0, tt}, 8'h08);
        chk("and_flags", flags(), 8'h20);
        chk("and_cnt", sample_cnt, 8'd4);
        chk("and_ready_low", {7'd0, in_ready}, 8'h00);
        send(0, 0, 1);
        chk("done_ignore_tt", {4'h0, tt}, 8'h08);
        chk("done_ignore_cnt", sample_cnt, 8'd4);

        // NAND with a duplicate row
        do_start();
        send(0, 0, 1); send(0, 1, 1); send(0, 1, 1); send(1, 0, 1); send(1, 1, 0);
        chk("nand_tt", {4'h0, tt}, 8'h07);
        chk("nand_flags", flags(), 8'h10);
        chk("nand_cnt", sample_cnt, 8'd5);
        chk("nand_conflict", {7'd0, conflict}, 8'h00);

        // conflict
        do_start();
        send(1, 1, 1);
        send(1, 1, 0);
        chk("cf_conflict", {7'd0, conflict}, 8'h01);
        chk("cf_tt3", {7'd0, tt[3]}, 8'h01);
        chk("cf_ready", {7'd0, in_ready}, 8'h00);
        chk("cf_done", {7'd0, done}, 8'h00);
        send(0, 0, 0);
        chk("cf_known_hold", {4'h0, known}, 8'h08);

        // asynchronous reset mid-collection
        do_start();
        send(0, 1, 1); send(1, 0, 1);
        reset_n = 1'b0;
        #1;
        chk("ar_tt", {4'h0, tt}, 8'h00);
        chk("ar_known", {4'h0, known}, 8'h00);
        chk("ar_cnt", sample_cnt, 8'd0);
        chk("ar_ready", {7'd0, in_ready}, 8'h00);
        tick();
        reset_n = 1'b1;
        do_start();
        send(0, 0, 0); send(0, 1, 1); send(1, 0, 1); send(1, 1, 0);
        chk("xor_tt", {4'h0, tt}, 8'h06);
        chk("xor_flags", flags(), 8'h02);

        // table matching no standard gate
        do_start();
        send(0, 0, 0); send(0, 1, 0); send(1, 0, 0); send(1, 1, 0);
        chk("zero_done", {7'd0, done}, 8'h01);
        chk("zero_flags", flags(), 8'h00);

        // start wins over a simultaneous sample
        start = 1'b1; in_valid = 1'b1; a = 0; b = 0; s = 1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("sp_known", {4'h0, known}, 8'h00);
        chk("sp_cnt", sample_cnt, 8'd0);
        chk("sp_ready", {7'd0, in_ready}, 8'h01);

        // idle timeout
        do_start();
        send(1, 1, 1);
        repeat (15) tick();
        chk("to_early", {7'd0, timeout}, 8'h00);
        chk("to_early_ready", {7'd0, in_ready}, 8'h01);
        tick();
`ifdef GATE_ID_TIMEOUT_EN
        chk("to_fire", {7'd0, timeout}, 8'h01);
        chk("to_ready", {7'd0, in_ready}, 8'h00);
`else
        chk("to_off", {7'd0, timeout}, 8'h00);
        chk("to_off_ready", {7'd0, in_ready}, 8'h01);
`endif

        // sample counter saturation on a single repeated row
        do_start();
        in_valid = 1'b1; a = 0; b = 0; s = 0;
        repeat (260) tick();
        in_valid = 1'b0;
        chk("sat_cnt", sample_cnt, 8'd255);
        chk("sat_ready", {7'd0, in_ready}, 8'h01);
        chk("sat_conflict", {7'd0, conflict}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_identifier.md
# gate_identifier

Sequential truth-table decoder for 2-input gate exercises. A bench or NAND-composed gate drives (a, b, s) observation samples in, one at a time. The block rebuilds the 4-entry truth table, detects contradictory samples, and reports which standard 2-input function was observed: AND, NAND, OR, NOR, XOR or XNOR. It sits on the response side of the guide's gate testbenches, next to the stimulus generator and the DUT/control pair.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 16: idle cycles allowed between samples in COLLECT. Used only when GATE_ID_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- start  input  1  one-cycle pulse; clears the table and enters COLLECT.
- in_valid  input  1  sample present this cycle.
- in_ready  output  1  high only in COLLECT.
- a  input  1  sample input a.
- b  input  1  sample input b.
- s  input  1  observed gate output for (a, b).
- tt  output  4  truth table; bit {a,b} holds s.
- known  output  4  bit {a,b} set once that row has been sampled.
- done  output  1  all 4 rows known, no conflict.
- conflict  output  1  the same row was seen with two different s values.
- timeout  output  1  timeout fired. Tied to 0 when the macro is absent.
- sample_cnt  output  8  accepted samples since start, saturates at 255.
- is_and, is_nand, is_or, is_nor, is_xor, is_xnor  output  1 each  function flags; valid only while done is high.

## Operation
- States: IDLE, COLLECT, DONE, ERROR. Encoding 2 bits, 00, 01, 10, 11.
- IDLE -> COLLECT on start.
- start from any state clears tt, known, sample_cnt, conflict and timeout, then enters COLLECT.
- A sample is accepted when in_valid and in_ready are both high. For the accepted sample, idx = {a,b}:
  - known[idx]=0: set tt[idx]=s and known[idx]=1.
  - known[idx]=1 and tt[idx]==s: row unchanged; sample_cnt still increments.
  - known[idx]=1 and tt[idx]!=s: set conflict=1 and go to ERROR. tt is not overwritten.
- COLLECT -> DONE on the edge where known becomes 4'b1111 without conflict.
- DONE and ERROR hold their outputs until the next start or reset. Samples offered in these states are ignored because in_ready is low.
- Function flags are decoded combinationally from tt, gated by done:
  - AND = 1000
  - NAND = 0111
  - OR = 1110
  - NOR = 0001
  - XOR = 0110
  - XNOR = 1001
- Any other table, such as 0000 or 1010, leaves every flag low with done still high.

## Timing
- Reset (async, reset_n=0): state=IDLE; tt, known, sample_cnt = 0; done, conflict, timeout, in_ready, and all flags = 0.
- Reset mid-collection discards all data immediately.
- Latency of one sample: tt, known and sample_cnt update on the same edge that accepts the sample.
- done rises on the edge that accepts the 4th distinct row. in_ready falls on that same edge.
- Minimum time to done: start edge plus 4 accepting edges.
- start and in_valid in the same cycle: start wins and the sample is dropped.
- sample_cnt saturates at 255 and does not wrap.

## Configuration
- GATE_ID_TIMEOUT_EN defined:
  - An idle counter runs in COLLECT. It resets on every accepted sample and on start.
  - When the counter reaches TIMEOUT_CYCLES consecutive cycles without an accepted sample, timeout=1 and the state goes to ERROR.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- GATE_ID_TIMEOUT_EN undefined: no counter is built, timeout is constant 0, and COLLECT waits indefinitely.

## Test plan
- AND table: reset, start, then feed (0,0,0), (0,1,0), (1,0,0), (1,1,1) one per cycle.
  - Required: done=1 one edge after the last sample, tt=1000, is_and=1, all other flags 0, sample_cnt=4.
- NAND built from NAND2 gates with a duplicate: feed the 4 rows, repeating row (0,1,1) once.
  - Required: tt=0111, is_nand=1, sample_cnt=5, conflict=0.
- Conflict: feed (1,1,1), then (1,1,0).
  - Required: conflict=1, state ERROR, tt[3] stays 1, in_ready=0, done=0.
- Reset mid-operation: after 2 samples, pulse reset_n low.
  - Required: all outputs 0 asynchronously, before the next edge.
  - Then start plus the 4 XOR rows gives tt=0110 and is_xor=1.
- start priority: assert start with in_valid=1 and sample (0,0,1).
  - Required: known=0000, sample_cnt=0 afterwards.
- Timeout (macro on, TIMEOUT_CYCLES=16): start, one sample, then 16 idle cycles.
  - Required: timeout=1 and ERROR on the 16th idle edge.
  - With the macro off, the same stimulus keeps the block in COLLECT with timeout=0.
